// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: per-register outstanding-write counters plus a global block for blocking instructions.
// Outputs are combinational from state and current inputs; all state moves on the next rising edge.

package maverickOne_pkg;
    localparam int NUM_REGS = 32;
endpackage

module reg_lock_tracker #(
    parameter int NR      = maverickOne_pkg::NUM_REGS,
    parameter int MAX_OUT = 4,
    localparam int AW     = $clog2(NR),
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          issue_i,
    input  logic          issue_blocking_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic          wb_valid_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic          blk_done_i,
    output logic [NR-1:0] locks_o,
    output logic          issue_full_o,
    output logic          blocked_o,
    output logic          idle_o,
    output logic          err_o
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_BLOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt     [NR];
    logic [CW-1:0]   w_cnt_nxt [NR];
    logic            r_err;
    logic            w_err_nxt;

    logic            w_inc_vld;
    logic            w_dec_vld;
    logic            w_any_busy;
    logic [NR-1:0]   w_cnt_nz;

    // Only a non-blocking issue from IDLE to a real register counts as a write.
    assign w_inc_vld = issue_i && !issue_blocking_i && (r_state == ST_IDLE) && (issue_rd_i != '0);
    assign w_dec_vld = wb_valid_i && (wb_rd_i != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        for (int i = 0; i < NR; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end

        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            for (int i = 0; i < NR; i++) begin
                w_cnt_nxt[i] = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (blk_done_i) begin
                        w_err_nxt = 1'b1;
                    end
                    if (issue_i && issue_blocking_i) begin
                        w_state_nxt = ST_BLOCKED;
                    end
                end
                ST_BLOCKED: begin
                    if (issue_i) begin
                        w_err_nxt = 1'b1;
                    end
                    if (blk_done_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            for (int i = 1; i < NR; i++) begin
                // A retiring write to the same rd cancels a new one, even at saturation.
                if (w_inc_vld && (issue_rd_i == AW'(i)) && w_dec_vld && (wb_rd_i == AW'(i))) begin
                    w_cnt_nxt[i] = r_cnt[i];
                end else if (w_inc_vld && (issue_rd_i == AW'(i))) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end else if (w_dec_vld && (wb_rd_i == AW'(i))) begin
                    if (r_cnt[i] == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            for (int i = 0; i < NR; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        w_cnt_nz = '0;
        for (int i = 1; i < NR; i++) begin
            w_cnt_nz[i] = (r_cnt[i] != '0);
        end
    end

    assign w_any_busy   = |w_cnt_nz;
    assign blocked_o    = (r_state == ST_BLOCKED);
    assign locks_o      = w_cnt_nz | {NR{blocked_o}};
    assign issue_full_o = (issue_rd_i != '0) && (r_cnt[issue_rd_i] == CNT_MAX);
    assign idle_o       = !w_any_busy && (r_state == ST_IDLE);
    assign err_o        = r_err;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Scoreboard bench for reg_lock_tracker: a reference model predicts post-edge outputs, queued at drive time and checked after the edge.
module tb_reg_lock_tracker;

    localparam int NR  = maverickOne_pkg::NUM_REGS;
    localparam int MO  = 4;
    localparam int AW  = $clog2(NR);

    logic          clk_i = 1'b0;
    logic          rst_ni, flush_i, issue_i, issue_blocking_i, wb_valid_i, blk_done_i;
    logic [AW-1:0] issue_rd_i, wb_rd_i;
    logic [NR-1:0] locks_o;
    logic          issue_full_o, blocked_o, idle_o, err_o;

    reg_lock_tracker #(.NR(NR), .MAX_OUT(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_i(issue_i), .issue_blocking_i(issue_blocking_i), .issue_rd_i(issue_rd_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .blk_done_i(blk_done_i),
        .locks_o(locks_o), .issue_full_o(issue_full_o), .blocked_o(blocked_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NR-1:0] locks;
        logic          blocked;
        logic          idle;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_cnt [NR];
    bit   m_blk;
    bit   m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.locks = '0;
        for (int i = 1; i < NR; i++) e.locks[i] = (m_cnt[i] != 0);
        if (m_blk) e.locks = '1;
        e.blocked = m_blk;
        e.idle    = (e.locks == '0) && !m_blk;
        e.err     = m_err;
        return e;
    endfunction

    task automatic model_step(input bit rst, input bit fl, input bit iss, input bit isb, input int ird,
                              input bit wb, input int wrd, input bit done);
        bit inc, dec;
        if (!rst) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_blk = 0;
            m_err = 0;
        end else if (fl) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            m_blk = 0;
        end else begin
            inc = iss && !isb && !m_blk && (ird != 0);
            dec = wb && (wrd != 0);
            if (iss && m_blk) m_err = 1;
            if (done && !m_blk) m_err = 1;
            if (!(inc && dec && ird == wrd)) begin
                if (inc) begin
                    if (m_cnt[ird] == MO) m_err = 1;
                    else m_cnt[ird]++;
                end
                if (dec) begin
                    if (m_cnt[wrd] == 0) m_err = 1;
                    else m_cnt[wrd]--;
                end
            end
            if (m_blk) begin
                if (done) m_blk = 0;
            end else if (iss && isb) begin
                m_blk = 1;
            end
        end
    endtask

    // One cycle: drive at negedge, check combinational full flag, queue prediction, compare after the edge.
    task automatic cyc(input bit rst = 1, input bit fl = 0, input bit iss = 0, input bit isb = 0,
                       input int ird = 0, input bit wb = 0, input int wrd = 0, input bit done = 0);
        exp_t e;
        @(negedge clk_i);
        rst_ni = rst; flush_i = fl; issue_i = iss; issue_blocking_i = isb;
        issue_rd_i = AW'(ird); wb_valid_i = wb; wb_rd_i = AW'(wrd); blk_done_i = done;
        #1;
        chk("issue_full", issue_full_o, (ird != 0) && (m_cnt[ird] == MO));
        model_step(rst, fl, iss, isb, ird, wb, wrd, done);
        exp_q.push_back(model_out());
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("locks", locks_o, e.locks);
            chk("blocked", blocked_o, e.blocked);
            chk("idle", idle_o, e.idle);
            chk("err", err_o, e.err);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_blk = 0; m_err = 0;
        rst_ni = 0; flush_i = 0; issue_i = 0; issue_blocking_i = 0;
        issue_rd_i = '0; wb_valid_i = 0; wb_rd_i = '0; blk_done_i = 0;

        // Reset and idle
        cyc(.rst(0)); cyc(.rst(0));
        chk("rst_locks", locks_o, 0); chk("rst_idle", idle_o, 1);
        chk("rst_blocked", blocked_o, 0); chk("rst_err", err_o, 0);
        cyc();

        // WAW on rd=5
        cyc(.iss(1), .ird(5)); chk("r5_lock_a", locks_o[5], 1);
        cyc(.iss(1), .ird(5)); chk("r5_lock_b", locks_o[5], 1);
        cyc(.wb(1), .wrd(5));  chk("r5_lock_c", locks_o[5], 1);
        cyc(.wb(1), .wrd(5));  chk("r5_lock_d", locks_o[5], 0);
        cyc(.iss(1), .ird(0)); chk("r0_lock", locks_o[0], 0); chk("r0_idle", idle_o, 1);

        // Saturation on rd=7
        repeat (4) cyc(.iss(1), .ird(7));
        cyc(.iss(1), .ird(7), .wb(1), .wrd(7));
        chk("r7_err_clean", err_o, 0);
        cyc(.iss(1), .ird(7)); chk("r7_overflow_err", err_o, 1);
        repeat (4) cyc(.wb(1), .wrd(7));
        chk("r7_drained", locks_o[7], 0);
        cyc(.rst(0));

        // Blocking with and without outstanding write
        cyc(.iss(1), .ird(3));
        cyc(.iss(1), .isb(1), .ird(12));
        chk("blk_all", locks_o, {NR{1'b1}}); chk("blk_state", blocked_o, 1);
        cyc(.wb(1), .wrd(3));
        cyc(.done(1)); chk("blk_done_locks", locks_o, 0); chk("blk_done_idle", idle_o, 1);
        cyc(.iss(1), .ird(3));
        cyc(.iss(1), .isb(1), .ird(3));
        cyc(.done(1)); chk("blk_keep3", locks_o, 32'h8); chk("blk_keep_err", err_o, 0);
        cyc(.wb(1), .wrd(3));

        // Illegal events
        cyc(.iss(1), .isb(1), .ird(1));
        cyc(.iss(1), .ird(4)); chk("blk_issue_err", err_o, 1);
        cyc(.done(1)); chk("blk_issue_ignored", locks_o[4], 0);
        cyc(.rst(0));
        cyc(.wb(1), .wrd(9)); chk("underflow_err", err_o, 1); chk("underflow_cnt", locks_o[9], 0);
        cyc(.rst(0));
        cyc(.done(1)); chk("idle_done_err", err_o, 1);
        cyc(.rst(0));
        cyc(.iss(1), .isb(1), .ird(6), .done(1));
        chk("done_blk_state", blocked_o, 1); chk("done_blk_err", err_o, 1);
        cyc(.done(1));

        // Flush and reset mid-BLOCKED
        cyc(.rst(0));
        cyc(.iss(1), .ird(2)); cyc(.iss(1), .ird(2));
        cyc(.iss(1), .isb(1), .ird(8));
        cyc(.fl(1), .iss(1), .ird(2), .wb(1), .wrd(2));
        chk("flush_locks", locks_o, 0); chk("flush_idle", idle_o, 1); chk("flush_blocked", blocked_o, 0);
        cyc(.iss(1), .isb(1), .ird(8));
        cyc(.iss(1), .ird(2));
        cyc(.rst(0), .iss(1), .ird(2));
        chk("rst_mid_locks", locks_o, 0); chk("rst_mid_err", err_o, 0); chk("rst_mid_idle", idle_o, 1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(.rst($urandom_range(0, 99) != 0), .fl($urandom_range(0, 49) == 0),
                .iss($urandom_range(0, 1) == 1), .isb($urandom_range(0, 15) == 0),
                .ird($urandom_range(0, 7)), .wb($urandom_range(0, 2) != 0),
                .wrd($urandom_range(0, 7)), .done($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
